// File: rtl/t05_spi_sched_pkg.sv
// ---------------------------------------------------------------------------
// t05_spi_sched_pkg
// Shared definitions for the SPI bit scheduler: the scheduler FSM state
// encoding and the default packed word width.
// ---------------------------------------------------------------------------
package t05_spi_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DAT,
        S_FLUSH
    } sched_state_t;

    localparam int BYTE_W_DEF = 8;

endpackage

// File: rtl/t05_bit_packer.sv
// ---------------------------------------------------------------------------
// t05_bit_packer
// Packs serial bits MSB-first into BYTE_W-bit words and presents them on a
// valid/ready output register. It can also zero-pad and emit a partial word.
//
// Ports:
//   clk, rst    - clock, synchronous active-low reset
//   bit_in      - serial data bit
//   bit_en      - bit_in is offered this cycle (taken unless stall)
//   pad         - emit the partial word zero-padded, once the output is free
//   byte_out    - packed word
//   byte_valid  - byte_out holds an undelivered word
//   byte_ready  - consumer takes byte_out this cycle
//   stall       - the offered bit cannot be taken this cycle
//   bit_cnt     - number of bits currently held in the partial word
// ---------------------------------------------------------------------------
module t05_bit_packer
    import t05_spi_sched_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bit_in,
    input  logic                      bit_en,
    input  logic                      pad,
    output logic [BYTE_W-1:0]         byte_out,
    output logic                      byte_valid,
    input  logic                      byte_ready,
    output logic                      stall,
    output logic [$clog2(BYTE_W)-1:0] bit_cnt
);

    localparam int CNT_W = $clog2(BYTE_W);
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(BYTE_W - 1);

    logic [BYTE_W-1:0] shreg;
    logic              accept;
    logic              byte_full;
    logic              pad_load;
    logic              load;

    // Only the bit that completes a word needs the output register, so only
    // that bit can be held off; a same-cycle drain frees the register in time.
    assign stall     = (bit_cnt == LAST_POS) && byte_valid && !byte_ready;
    assign accept    = bit_en && !stall;
    assign byte_full = accept && (bit_cnt == LAST_POS);
    assign pad_load  = pad && (bit_cnt != '0) && (!byte_valid || byte_ready);
    assign load      = byte_full || pad_load;

    // shreg is cleared whenever its contents move to the output register, so
    // the unused low bits of a partial word are already zero when padding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            if (byte_full) begin
                byte_out <= {shreg[BYTE_W-1:1], bit_in};
                shreg    <= '0;
                bit_cnt  <= '0;
            end else if (accept) begin
                shreg[LAST_POS - bit_cnt] <= bit_in;
                bit_cnt                   <= bit_cnt + 1'b1;
            end else if (pad_load) begin
                byte_out <= shreg;
                shreg    <= '0;
                bit_cnt  <= '0;
            end

            if (load) begin
                byte_valid <= 1'b1;
            end else if (byte_ready) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/t05_spi_bit_scheduler.sv
// ---------------------------------------------------------------------------
// t05_spi_bit_scheduler
// Shares one SPI byte-write port between a header bit stream and an encoded
// data bit stream. Whole bursts are granted with fixed priority (header
// first); granted bits are packed MSB-first into bytes, and a flush pads and
// emits any remaining partial byte.
//
// Ports:
//   clk, rst                                   - clock, sync active-low reset
//   hdr_req/hdr_bit_valid/hdr_bit/hdr_last     - header producer
//   hdr_grant                                  - header owns the channel
//   dat_req/dat_bit_valid/dat_bit/dat_last     - data producer
//   dat_grant                                  - data owns the channel
//   stall                                      - granted producer must hold
//   flush, flush_done                          - pad request / completion
//   byte_out, byte_valid, byte_ready           - SPI byte handshake
//   busy                                       - not idle or a byte pending
// ---------------------------------------------------------------------------
module t05_spi_bit_scheduler
    import t05_spi_sched_pkg::*;
#(
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hdr_req,
    input  logic              hdr_bit_valid,
    input  logic              hdr_bit,
    input  logic              hdr_last,
    output logic              hdr_grant,
    input  logic              dat_req,
    input  logic              dat_bit_valid,
    input  logic              dat_bit,
    input  logic              dat_last,
    output logic              dat_grant,
    output logic              stall,
    input  logic              flush,
    output logic              flush_done,
    output logic [BYTE_W-1:0] byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              busy
);

    sched_state_t              state;
    logic                      cur_valid;
    logic                      cur_bit;
    logic                      cur_last;
    logic                      accepted;
    logic [$clog2(BYTE_W)-1:0] bit_cnt;

    // Route the granted stream to the packer; the other stream is ignored.
    always_comb begin
        cur_valid = 1'b0;
        cur_bit   = 1'b0;
        cur_last  = 1'b0;
        case (state)
            S_HDR: begin
                cur_valid = hdr_bit_valid;
                cur_bit   = hdr_bit;
                cur_last  = hdr_last;
            end
            S_DAT: begin
                cur_valid = dat_bit_valid;
                cur_bit   = dat_bit;
                cur_last  = dat_last;
            end
            default: ;
        endcase
    end

    assign accepted  = cur_valid && !stall;
    assign hdr_grant = (state == S_HDR);
    assign dat_grant = (state == S_DAT);
    assign busy      = (state != S_IDLE) || byte_valid;

    // Burst arbitration and flush sequencing. A flush coinciding with a
    // request loses to the request. Flush completes only once the packer is
    // empty and the output register has drained.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hdr_req) begin
                        state <= S_HDR;
                    end else if (dat_req) begin
                        state <= S_DAT;
                    end else if (flush) begin
                        state <= S_FLUSH;
                    end
                end
                S_HDR, S_DAT: begin
                    if (accepted && cur_last) begin
                        state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if ((bit_cnt == '0) && !byte_valid) begin
                        flush_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    t05_bit_packer #(
        .BYTE_W (BYTE_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (cur_bit),
        .bit_en     (cur_valid),
        .pad        (state == S_FLUSH),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .stall      (stall),
        .bit_cnt    (bit_cnt)
    );

endmodule

// File: tb/tb_t05_spi_bit_scheduler.sv
// ---------------------------------------------------------------------------
// tb_t05_spi_bit_scheduler
// Directed bench for the SPI bit scheduler: reset state, a padded header
// burst, arbitration, backpressure, same-cycle drain, empty flush and reset
// in the middle of a burst. Delivered bytes are collected by a monitor.
// ---------------------------------------------------------------------------
module tb_t05_spi_bit_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       hdr_req, hdr_bit_valid, hdr_bit, hdr_last, hdr_grant;
    logic       dat_req, dat_bit_valid, dat_bit, dat_last, dat_grant;
    logic       stall, flush, flush_done, byte_valid, byte_ready, busy;
    logic [7:0] byte_out;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    t05_spi_bit_scheduler #(
        .BYTE_W (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hdr_req       (hdr_req),
        .hdr_bit_valid (hdr_bit_valid),
        .hdr_bit       (hdr_bit),
        .hdr_last      (hdr_last),
        .hdr_grant     (hdr_grant),
        .dat_req       (dat_req),
        .dat_bit_valid (dat_bit_valid),
        .dat_bit       (dat_bit),
        .dat_last      (dat_last),
        .dat_grant     (dat_grant),
        .stall         (stall),
        .flush         (flush),
        .flush_done    (flush_done),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .busy          (busy)
    );

    // Record every byte handed over to the SPI (inputs are stable at negedge).
    always @(negedge clk) begin
        if (rst && byte_valid && byte_ready) got_q.push_back(byte_out);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive n bits (MSB of the n-bit field first) on one stream, one per
    // cycle; these bits are all expected to be taken without stalling.
    task automatic drive_bits(input logic use_hdr, input logic [15:0] bits,
                              input int n, input logic mark_last);
        for (int i = 0; i < n; i++) begin
            if (use_hdr) begin
                hdr_bit_valid = 1'b1;
                hdr_bit       = bits[n-1-i];
                hdr_last      = mark_last && (i == n - 1);
            end else begin
                dat_bit_valid = 1'b1;
                dat_bit       = bits[n-1-i];
                dat_last      = mark_last && (i == n - 1);
            end
            #1;
            vectors++;
            if (stall !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bit_no_stall[%0d]: got %b want 0", i, stall);
            end
            step();
        end
        hdr_bit_valid = 1'b0;
        hdr_last      = 1'b0;
        dat_bit_valid = 1'b0;
        dat_last      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        vectors += 7;
        if (hdr_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_hdr_grant: got %b want 0", hdr_grant); end
        if (dat_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_dat_grant: got %b want 0", dat_grant); end
        if (byte_out !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_byte_out: got %h want 00", byte_out); end
        if (byte_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_byte_valid: got %b want 0", byte_valid); end
        if (flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_flush_done: got %b want 0", flush_done); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
        if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stall: got %b want 0", stall); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_hdr();
        int g;
        got_q.delete();
        byte_ready = 1'b1;
        hdr_req    = 1'b1;
        step();
        hdr_req = 1'b0;
        vectors++;
        if (hdr_grant !== 1'b1) begin miscompares++; $display("[TB] FAIL hdr_grant_up: got %b want 1", hdr_grant); end
        drive_bits(1'b1, 16'b101_0000_0100, 11, 1'b1);
        vectors++;
        if (hdr_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL hdr_grant_drop: got %b want 0", hdr_grant); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        g = 0;
        while (g < 20 && flush_done !== 1'b1) begin
            step();
            g++;
        end
        vectors += 2;
        if (flush_done !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_done_timeout: got %b want 1", flush_done); end
        if (byte_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_drained: got %b want 0", byte_valid); end
        step();
        vectors += 2;
        if (flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_done_pulse: got %b want 0", flush_done); end
        if (got_q.size() != 2 || got_q[0] !== 8'hA0 || got_q[1] !== 8'h80) begin
            miscompares++;
            $display("[TB] FAIL hdr_bytes: got %0d bytes %p want A0 80", got_q.size(), got_q);
        end
    endtask

    task automatic test_simultaneous();
        got_q.delete();
        byte_ready = 1'b1;
        hdr_req    = 1'b1;
        dat_req    = 1'b1;
        step();
        hdr_req = 1'b0;
        vectors += 2;
        if (hdr_grant !== 1'b1) begin miscompares++; $display("[TB] FAIL prio_hdr: got %b want 1", hdr_grant); end
        if (dat_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL prio_dat_low: got %b want 0", dat_grant); end
        drive_bits(1'b1, 16'b1011, 4, 1'b1);
        vectors += 2;
        if (hdr_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_hdr: got %b want 0", hdr_grant); end
        if (dat_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_dat: got %b want 0", dat_grant); end
        step();
        vectors += 2;
        if (dat_grant !== 1'b1) begin miscompares++; $display("[TB] FAIL dat_grant_up: got %b want 1", dat_grant); end
        if (hdr_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL excl_hdr: got %b want 0", hdr_grant); end
        dat_req = 1'b0;
        drive_bits(1'b0, 16'b0110, 4, 1'b1);
        step();
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 8'hB6) begin
            miscompares++;
            $display("[TB] FAIL contiguous_byte: got %0d bytes %p want B6", got_q.size(), got_q);
        end
    endtask

    task automatic test_backpressure();
        got_q.delete();
        byte_ready = 1'b0;
        dat_req    = 1'b1;
        step();
        dat_req = 1'b0;
        drive_bits(1'b0, 16'hFF0F >> 1, 15, 1'b0);
        dat_bit_valid = 1'b1;
        dat_bit       = 1'b1;
        dat_last      = 1'b1;
        #1;
        vectors += 2;
        if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_stall: got %b want 1", stall); end
        if (byte_out !== 8'hFF) begin miscompares++; $display("[TB] FAIL bp_first_byte: got %h want FF", byte_out); end
        step();
        vectors += 2;
        if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_hold: got %b want 1", stall); end
        if (dat_grant !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_grant_kept: got %b want 1", dat_grant); end
        byte_ready = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release: got %b want 0", stall); end
        step();
        dat_bit_valid = 1'b0;
        dat_last      = 1'b0;
        vectors += 2;
        if (byte_valid !== 1'b1 || byte_out !== 8'h0F) begin
            miscompares++;
            $display("[TB] FAIL bp_second_byte: got v=%b %h want v=1 0F", byte_valid, byte_out);
        end
        if (dat_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_burst_end: got %b want 0", dat_grant); end
        step();
        vectors++;
        if (got_q.size() != 2 || got_q[0] !== 8'hFF || got_q[1] !== 8'h0F) begin
            miscompares++;
            $display("[TB] FAIL bp_bytes: got %0d bytes %p want FF 0F", got_q.size(), got_q);
        end
    endtask

    task automatic test_back_to_back();
        got_q.delete();
        byte_ready = 1'b0;
        dat_req    = 1'b1;
        step();
        dat_req = 1'b0;
        drive_bits(1'b0, 16'h5AC3 >> 1, 15, 1'b0);
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL b2b_pending: got v=%b %h want v=1 5A", byte_valid, byte_out);
        end
        dat_bit_valid = 1'b1;
        dat_bit       = 1'b1;
        dat_last      = 1'b1;
        byte_ready    = 1'b1;
        #1;
        vectors++;
        if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_no_stall: got %b want 0", stall); end
        step();
        dat_bit_valid = 1'b0;
        dat_last      = 1'b0;
        vectors++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hC3) begin
            miscompares++;
            $display("[TB] FAIL b2b_no_bubble: got v=%b %h want v=1 C3", byte_valid, byte_out);
        end
        step();
        vectors++;
        if (got_q.size() != 2 || got_q[0] !== 8'h5A || got_q[1] !== 8'hC3) begin
            miscompares++;
            $display("[TB] FAIL b2b_bytes: got %0d bytes %p want 5A C3", got_q.size(), got_q);
        end
    endtask

    task automatic test_flush_empty();
        got_q.delete();
        byte_ready = 1'b1;
        flush      = 1'b1;
        step();
        flush = 1'b0;
        vectors += 2;
        if (flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_early: got %b want 0", flush_done); end
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL fe_busy: got %b want 1", busy); end
        step();
        vectors++;
        if (flush_done !== 1'b1) begin miscompares++; $display("[TB] FAIL fe_done: got %b want 1", flush_done); end
        step();
        vectors += 3;
        if (flush_done !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_one_cycle: got %b want 0", flush_done); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL fe_idle: got %b want 0", busy); end
        if (got_q.size() != 0) begin miscompares++; $display("[TB] FAIL fe_no_byte: got %0d bytes want 0", got_q.size()); end
    endtask

    task automatic test_reset_mid_burst();
        byte_ready = 1'b1;
        hdr_req    = 1'b1;
        step();
        hdr_req = 1'b0;
        drive_bits(1'b1, 16'b11111, 5, 1'b0);
        rst = 1'b0;
        step();
        vectors += 6;
        if (hdr_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_hdr_grant: got %b want 0", hdr_grant); end
        if (dat_grant !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_dat_grant: got %b want 0", dat_grant); end
        if (byte_out !== 8'h00) begin miscompares++; $display("[TB] FAIL rm_byte_out: got %h want 00", byte_out); end
        if (byte_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_byte_valid: got %b want 0", byte_valid); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_busy: got %b want 0", busy); end
        if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_stall: got %b want 0", stall); end
        rst = 1'b1;
        step();
        got_q.delete();
        hdr_req = 1'b1;
        step();
        hdr_req = 1'b0;
        drive_bits(1'b1, 16'h003C, 8, 1'b1);
        step();
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
            miscompares++;
            $display("[TB] FAIL rm_clean_byte: got %0d bytes %p want 3C", got_q.size(), got_q);
        end
    endtask

    initial begin
        rst           = 1'b0;
        hdr_req       = 1'b0;
        hdr_bit_valid = 1'b0;
        hdr_bit       = 1'b0;
        hdr_last      = 1'b0;
        dat_req       = 1'b0;
        dat_bit_valid = 1'b0;
        dat_bit       = 1'b0;
        dat_last      = 1'b0;
        flush         = 1'b0;
        byte_ready    = 1'b0;

        test_reset();
        test_single_hdr();
        test_simultaneous();
        test_backpressure();
        test_back_to_back();
        test_flush_empty();
        test_reset_mid_burst();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
